// File: rtl/dense_in_frame_packer.sv
// Double-buffered packer: collects NB_INPUT feature words and presents them as one flat frame.
// Define DENSE_IN_PACKER_FRAME_CNT_EN to add the 16-bit frame_cnt transfer counter output.
module dense_in_frame_packer #(
    parameter int FIXED    = 32,
    parameter int NB_INPUT = 42,
    parameter int CNT_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FIXED-1:0]          in_data,
    input  logic                      in_sof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NB_INPUT*FIXED-1:0] out_frame,
`ifdef DENSE_IN_PACKER_FRAME_CNT_EN
    output logic [15:0]               frame_cnt,
`endif
    output logic                      sof_err
);

    typedef logic [NB_INPUT-1:0][FIXED-1:0] bank_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB_INPUT - 1);

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_sync_n;
    bank_t            collect_q, collect_d;
    bank_t            out_frame_q, out_frame_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             collect_full_q, collect_full_d;
    logic             out_valid_q, out_valid_d;
    logic             sof_err_q, sof_err_d;
    logic             accept;
    logic             transfer;

    // Reset asserts immediately but is released only on a clock edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    assign in_ready  = !collect_full_q;
    assign accept    = in_valid && in_ready;
    assign transfer  = collect_full_q && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_frame = out_frame_q;
    assign sof_err   = sof_err_q;

    // Accept and transfer are mutually exclusive: one needs the collect bank empty, the other full.
    always_comb begin
        collect_d      = collect_q;
        out_frame_d    = out_frame_q;
        count_d        = count_q;
        collect_full_d = collect_full_q;
        out_valid_d    = out_valid_q;
        sof_err_d      = 1'b0;

        if (accept) begin
            if (in_sof && (count_q != '0)) begin
                collect_d[0] = in_data;
                count_d      = CNT_W'(1);
                sof_err_d    = 1'b1;
            end else begin
                collect_d[count_q] = in_data;
                if (count_q == LAST_IDX) begin
                    count_d        = '0;
                    collect_full_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end

        if (transfer) begin
            out_frame_d    = collect_q;
            out_valid_d    = 1'b1;
            collect_full_d = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            collect_q      <= '0;
            out_frame_q    <= '0;
            count_q        <= '0;
            collect_full_q <= 1'b0;
            out_valid_q    <= 1'b0;
            sof_err_q      <= 1'b0;
        end else begin
            collect_q      <= collect_d;
            out_frame_q    <= out_frame_d;
            count_q        <= count_d;
            collect_full_q <= collect_full_d;
            out_valid_q    <= out_valid_d;
            sof_err_q      <= sof_err_d;
        end
    end

`ifdef DENSE_IN_PACKER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (transfer) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_dense_in_frame_packer.sv
// Scoreboard bench for dense_in_frame_packer: the driver models the packer and queues the
// expected frames, the negedge monitor pops and compares on every output handshake.
module tb_dense_in_frame_packer;

   localparam int FIXED = 32;
   localparam int NB    = 42;
   localparam int CNT_W = 6;

   typedef logic [NB*FIXED-1:0] frame_t;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        in_valid  = 1'b0;
   logic        in_sof    = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data   = '0;
   logic        in_ready;
   logic        out_valid;
   logic        sof_err;
   frame_t      out_frame;
`ifdef DENSE_IN_PACKER_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int checks = 0;
   int errors = 0;
   frame_t exp_q[$];
   frame_t hist[$];
   logic [31:0] mslots[NB];
   int mcount = 0;
   int exp_sof_pulses = 0;
   int sof_hi = 0;
   bit rand_en = 1'b0;

   dense_in_frame_packer #(.FIXED(FIXED), .NB_INPUT(NB), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sof    (in_sof),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_frame (out_frame),
`ifdef DENSE_IN_PACKER_FRAME_CNT_EN
      .frame_cnt (frame_cnt),
`endif
      .sof_err   (sof_err)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic checkFrame(input string name, input frame_t got, input frame_t exp);
      int bad;
      bad = -1;
      checks++;
      for (int k = NB - 1; k >= 0; k--) begin
         if (got[k*FIXED +: FIXED] !== exp[k*FIXED +: FIXED]) bad = k;
      end
      if (bad >= 0) begin
         errors++;
         $display("[TB] FAIL %s word %0d: got %h, expected %h", name, bad,
                  got[bad*FIXED +: FIXED], exp[bad*FIXED +: FIXED]);
      end
   endtask

   // Monitor: a frame is consumed at the posedge following a negedge that sees valid && ready.
   always @(negedge clk) begin
      if (rst_n && sof_err) sof_hi++;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got out_valid=1, expected no frame pending");
         end else begin
            checkFrame("frame", out_frame, exp_q.pop_front());
         end
      end
   end

   // Random downstream readiness, changed just after each rising edge while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_en) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pushFrame();
      frame_t f;
      for (int k = 0; k < NB; k++) f[k*FIXED +: FIXED] = mslots[k];
      exp_q.push_back(f);
      hist.push_back(f);
   endtask

   // Drives one word, waits (bounded) for acceptance, then updates the reference model.
   task automatic applyStimulus(input logic [31:0] d, input logic sof, input int gap);
      int t;
      bit exp_err;
      in_valid = 1'b0;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
         in_valid = 1'b0;
         in_sof   = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      exp_err = sof && (mcount != 0);
      if (exp_err) begin
         mcount = 0;
         exp_sof_pulses++;
      end
      mslots[mcount] = d;
      mcount++;
      if (mcount == NB) begin
         pushFrame();
         mcount = 0;
      end
      checkOutput("sof_err", 32'(sof_err), 32'(exp_err));
   endtask

   task automatic sendWords(input int base, input int first, input int num, input int maxgap);
      for (int k = first; k < first + num; k++) begin
         applyStimulus(32'(base + k), k == 0, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      end
   endtask

   task automatic drain();
      int t;
      rand_en   = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      checkOutput("frames_pending", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic assertReset();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst_n    = 1'b0;
      exp_q.delete();
      mcount = 0;
      #1;
   endtask

   task automatic releaseReset();
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      frame_t a_frame;
      frame_t b_frame;

      // Reset state.
      #2;
      assertReset();
      releaseReset();
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_sof_err", 32'(sof_err), 32'd0);
      checkFrame("reset_out_frame", out_frame, '0);

      // One frame of k+1 with downstream always ready; check the two-cycle output latency.
      out_ready = 1'b1;
      sendWords(1, 0, NB, 0);
      checkOutput("lat_out_valid_T", 32'(out_valid), 32'd0);
      checkOutput("lat_in_ready_T", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("lat_out_valid_T1", 32'(out_valid), 32'd1);
      checkOutput("lat_in_ready_T1", 32'(in_ready), 32'd1);
      drain();
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

      // Two frames with downstream stalled: frame 1 held, frame 2 parked in the collect bank.
      out_ready = 1'b0;
      sendWords(100, 0, NB, 0);
      sendWords(200, 0, NB, 0);
      a_frame = hist[hist.size() - 2];
      b_frame = hist[hist.size() - 1];
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkFrame("hold_frame1", out_frame, a_frame);
      repeat (3) @(posedge clk);
      #1;
      checkFrame("hold_frame1_later", out_frame, a_frame);
      checkOutput("hold_in_ready_later", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("b2b_out_valid", 32'(out_valid), 32'd1);
      checkFrame("b2b_frame2", out_frame, b_frame);
      checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
      drain();

      // Mid-frame sof restart after 10 words.
      sendWords(300, 0, 10, 0);
      applyStimulus(32'hA5A5A5A5, 1'b1, 0);
      sendWords(400, 1, NB - 1, 0);
      drain();

      // Three frames with random input gaps and random downstream readiness.
      rand_en = 1'b1;
      for (int f = 0; f < 3; f++) sendWords(32'h0400_0000 + f * 256, 0, NB, 5);
      drain();

      // Asynchronous reset between edges while a frame is held and another is half collected.
      out_ready = 1'b0;
      sendWords(500, 0, NB, 0);
      sendWords(550, 0, 20, 0);
      checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
      #3;
      assertReset();
      checkOutput("async_out_valid", 32'(out_valid), 32'd0);
      checkFrame("async_out_frame", out_frame, '0);
      checkOutput("async_in_ready", 32'(in_ready), 32'd1);
      releaseReset();
      out_ready = 1'b1;
      sendWords(600, 0, NB, 0);
      drain();

      // Three delivered frames plus one sof-restart discard.
      #3;
      assertReset();
      releaseReset();
      out_ready = 1'b1;
      sendWords(700, 0, NB, 0);
      sendWords(800, 0, 15, 0);
      applyStimulus(32'hDEADBEEF, 1'b1, 0);
      sendWords(850, 1, NB - 1, 0);
      sendWords(900, 0, NB, 0);
      drain();
`ifdef DENSE_IN_PACKER_FRAME_CNT_EN
      checkOutput("frame_cnt", 32'(frame_cnt), 32'd3);
`endif

      checkOutput("sof_err_pulse_cycles", 32'(sof_hi), 32'(exp_sof_pulses));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
